// File: rtl/maze_game_ctrl.sv
// Game sequencer around maze_generator: restart, wait, then own the player.
// Ports: clk/rst, new_game, move_valid/move_dir, h_walls/v_walls, gen_busy in;
//        gen_rst, playing, player_row/col, move_ack, bump, win, level, moves out.
module maze_game_ctrl #(
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 15,
  parameter int MOVE_GAP = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        new_game,
  input  logic                        move_valid,
  input  logic [1:0]                  move_dir,
  input  logic [WIDTH*(HEIGHT+1)-1:0] h_walls,
  input  logic [HEIGHT*(WIDTH+1)-1:0] v_walls,
  input  logic                        gen_busy,
  output logic                        gen_rst,
  output logic                        playing,
  output logic [3:0]                  player_row,
  output logic [3:0]                  player_col,
  output logic                        move_ack,
  output logic                        bump,
  output logic                        win,
  output logic [7:0]                  level,
  output logic [15:0]                 moves
);

  localparam int HW = WIDTH * (HEIGHT + 1);
  localparam int VW = HEIGHT * (WIDTH + 1);
  localparam int CW = (MOVE_GAP > 0) ? $clog2(MOVE_GAP + 1) : 1;
  localparam logic [CW-1:0] GAP = CW'(MOVE_GAP);
  localparam logic [3:0] EXIT_R = 4'(HEIGHT - 1);
  localparam logic [3:0] EXIT_C = 4'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_GEN_RST,
    S_GEN_SETTLE,
    S_GEN_WAIT,
    S_PLAY,
    S_WIN
  } state_t;

  state_t          state;
  logic            rst_cnt;
  logic [CW-1:0]   cooldown;

  logic [HW-1:0]   hsh;
  logic [VW-1:0]   vsh;
  logic            blocked;
  logic [3:0]      nr;
  logic [3:0]      nc;

  // Wall lookup: shift the wall vector so the bit of interest lands at 0.
  // Border tests come first so a missing border bit never lets us leave.
  always_comb begin
    hsh     = '0;
    vsh     = '0;
    blocked = 1'b1;
    nr      = player_row;
    nc      = player_col;
    unique case (1'b1)
      (move_dir == 2'd0): begin
        hsh     = h_walls >> (int'(player_row) * WIDTH
                              + int'(player_col));
        blocked = (player_row == 4'd0) || hsh[0];
        nr      = player_row - 4'd1;
      end
      (move_dir == 2'd1): begin
        vsh     = v_walls >> (int'(player_row) * (WIDTH + 1)
                              + int'(player_col) + 1);
        blocked = (player_col == EXIT_C) || vsh[0];
        nc      = player_col + 4'd1;
      end
      (move_dir == 2'd2): begin
        hsh     = h_walls >> ((int'(player_row) + 1) * WIDTH
                              + int'(player_col));
        blocked = (player_row == EXIT_R) || hsh[0];
        nr      = player_row + 4'd1;
      end
      (move_dir == 2'd3): begin
        vsh     = v_walls >> (int'(player_row) * (WIDTH + 1)
                              + int'(player_col));
        blocked = (player_col == 4'd0) || vsh[0];
        nc      = player_col - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_GEN_RST;
      rst_cnt    <= 1'b0;
      cooldown   <= '0;
      gen_rst    <= 1'b1;
      playing    <= 1'b0;
      player_row <= 4'd0;
      player_col <= 4'd0;
      move_ack   <= 1'b0;
      bump       <= 1'b0;
      win        <= 1'b0;
      level      <= 8'd0;
      moves      <= 16'd0;
    end else begin
      move_ack <= 1'b0;
      bump     <= 1'b0;
      win      <= 1'b0;
      if (cooldown != '0)
        cooldown <= cooldown - CW'(1);
      if (new_game) begin
        state   <= S_GEN_RST;
        rst_cnt <= 1'b0;
        gen_rst <= 1'b1;
        playing <= 1'b0;
        level   <= 8'd0;
      end else begin
        case (state)
          S_GEN_RST: begin
            if (rst_cnt) begin
              state   <= S_GEN_SETTLE;
              rst_cnt <= 1'b0;
              gen_rst <= 1'b0;
            end else begin
              rst_cnt <= 1'b1;
            end
          end
          S_GEN_SETTLE: state <= S_GEN_WAIT;
          S_GEN_WAIT: begin
            if (!gen_busy) begin
              state      <= S_PLAY;
              playing    <= 1'b1;
              player_row <= 4'd0;
              player_col <= 4'd0;
              moves      <= 16'd0;
              cooldown   <= '0;
            end
          end
          S_PLAY: begin
            if (move_valid && cooldown == '0) begin
              cooldown <= GAP;
              if (blocked) begin
                bump <= 1'b1;
              end else begin
                move_ack   <= 1'b1;
                player_row <= nr;
                player_col <= nc;
                if (moves != 16'hFFFF)
                  moves <= moves + 16'd1;
                if (nr == EXIT_R && nc == EXIT_C) begin
                  state   <= S_WIN;
                  win     <= 1'b1;
                  playing <= 1'b0;
                  if (level != 8'hFF)
                    level <= level + 8'd1;
                end
              end
            end
          end
          S_WIN: begin
            state   <= S_GEN_RST;
            rst_cnt <= 1'b0;
            gen_rst <= 1'b1;
          end
          default: begin
            state   <= S_GEN_RST;
            rst_cnt <= 1'b0;
            gen_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Game-level controller that sequences maze_generator: restarts it (via its reset), waits for generation to finish, then owns the player position inside the generated maze.
- Validates each move request against the wall vectors, counts moves, detects arrival at the exit cell and automatically requests the next maze.
- Sits between input handling (buttons/UART) and the maze generator / display logic.

Parameters:
- WIDTH, 10, maze columns (cells per row)
- HEIGHT, 15, maze rows
- MOVE_GAP, 4, minimum cycles between accepted moves (cooldown after any accept or bump)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- new_game  in  1  level-sampled pulse: restart from level 0
- move_valid  in  1  move request strobe
- move_dir  in  2  0=up, 1=right, 2=down, 3=left
- h_walls  in  WIDTH*(HEIGHT+1)  bit r*WIDTH+c = wall on top edge of cell (r,c); row HEIGHT = bottom border
- v_walls  in  HEIGHT*(WIDTH+1)  bit r*(WIDTH+1)+c = wall on left edge of cell (r,c); column WIDTH = right border
- gen_busy  in  1  maze_generator busy
- gen_rst  out  1  reset to maze_generator (and its random_byte)
- playing  out  1  high in PLAY state
- player_row  out  4  current row
- player_col  out  4  current column
- move_ack  out  1  one-cycle pulse: move accepted
- bump  out  1  one-cycle pulse: move rejected by wall/border
- win  out  1  one-cycle pulse: exit reached
- level  out  8  mazes completed since new_game, saturates at 255
- moves  out  16  accepted moves in current maze, saturates at 65535

Behaviour:
- Reset: state=GEN_RST, gen_rst=1, playing=0, player_row/col=0, move_ack=bump=win=0, level=0, moves=0, cooldown=0.
- States: GEN_RST -> GEN_SETTLE -> GEN_WAIT -> PLAY -> WIN -> GEN_RST.
- GEN_RST: gen_rst=1 for exactly 2 cycles (internal counter), then GEN_SETTLE.
- GEN_SETTLE: gen_rst=0, one cycle, gen_busy ignored; then GEN_WAIT.
- GEN_WAIT: stay while gen_busy=1; on gen_busy=0 go to PLAY, player_row/col=0, moves=0, cooldown=0.
- PLAY: playing=1. When move_valid=1 and cooldown=0, evaluate move against current position (r,c):
  - up blocked if r==0 or h_walls[r*WIDTH+c]
  - down blocked if r==HEIGHT-1 or h_walls[(r+1)*WIDTH+c]
  - left blocked if c==0 or v_walls[r*(WIDTH+1)+c]
  - right blocked if c==WIDTH-1 or v_walls[r*(WIDTH+1)+c+1]
  - Border checks override wall bits (out-of-grid never reachable even if border bit is 0).
  - Not blocked: position updates next edge, move_ack pulses same edge, moves+1 (saturating).
  - Blocked: position unchanged, bump pulses, moves unchanged.
  - Either case loads cooldown=MOVE_GAP; cooldown decrements each cycle to 0. move_valid while cooldown≠0 ignored (no pulse).
  - MOVE_GAP=0: one move per cycle.
- Exit cell = (HEIGHT-1, WIDTH-1). Accepted move landing on it -> next state WIN.
- WIN: one cycle, win=1, level+1 (saturating at 255), playing=0, then GEN_RST. moves and position hold until GEN_WAIT exits.
- new_game=1 in any state (incl. mid-generation): next state GEN_RST, 2-cycle count restarts, level=0; moves ignored that cycle. new_game has priority over move_valid and over WIN transition (no win pulse, level=0).
- Moves outside PLAY: ignored, no ack/bump.
- gen_busy outside GEN_WAIT ignored.
- Async rst mid-operation: all state to reset values immediately; gen_rst asserts asynchronously.
- All outputs registered; move latency 1 cycle from sampled request to position/pulse.

Test Plan:
- Release rst with generator model busy for 50 cycles -> gen_rst high exactly 2 cycles after reset release, playing rises 1 cycle after gen_busy falls, position (0,0), moves=0.
- At (0,0) request up, then left -> two bump pulses, position (0,0), moves=0; cooldown: second request inside 4 cycles produces no pulse.
- Open maze (all interior walls 0), right x9 then down x14, MOVE_GAP spacing -> 23 move_ack, win on 23rd move's following cycle, level=1, gen_rst reasserted, moves=23 until next PLAY.
- h_walls bit 1*WIDTH+0 =1 at (0,0), request down -> bump; clear bit -> move_ack, position (1,0).
- new_game asserted same cycle as winning move -> no win pulse, level=0, gen_rst 2 cycles.
- Async rst pulse of 0.5 cycle during PLAY at (3,4) -> outputs return to reset values without clock edge; full sequence restarts.
